// File: rtl/ppu_pkg.sv
// Shared PPU hazard types: forwarding-select encodings, register-index width
// and the per-stage destination shadow used by the hazard/forwarding logic.
package ppu_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [REG_ADDR_W_DEFAULT-1:0] rd;
    logic                          rf_en;
    logic                          load;
  } stage_shadow_t;

  // x0 never counts as a write target, however the control bits are set.
  function automatic logic stage_writes(input stage_shadow_t st,
                                        input logic [REG_ADDR_W_DEFAULT-1:0] r,
                                        input int num_regs);
    return st.rf_en && (st.rd == r) && (st.rd != '0) && (int'(st.rd) < num_regs);
  endfunction

endpackage

// File: rtl/hazard_forwarding_unit_fwd_select.sv
// Per-operand forwarding selector: picks the youngest stage that writes the
// source register, skipping an EX-stage load whose data does not exist yet.
module fwd_select
  import ppu_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic [REG_ADDR_W_DEFAULT-1:0] rs,
  input  logic                          uses,
  input  stage_shadow_t                 ex_st,
  input  stage_shadow_t                 mem_st,
  input  stage_shadow_t                 wb_st,
  output logic [1:0]                    sel
);

  always_comb begin
    sel = FWD_RF;
    if (uses) begin
      if (stage_writes(ex_st, rs, NUM_REGS) && !ex_st.load) begin
        sel = FWD_EX;
      end else if (stage_writes(mem_st, rs, NUM_REGS)) begin
        sel = FWD_MEM;
      end else if (stage_writes(wb_st, rs, NUM_REGS)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// Hazard/forwarding controller for the 5-stage PPU: load-use stall, branch
// flush, memory freeze and operand forwarding. HAZARD_PERF_CNT_EN adds counters.
module hazard_forwarding_unit
  import ppu_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_uses_rs1,
  input  logic                  ID_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic                  ID_RF_Enable,
  input  logic                  ID_Load_Instr,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  cu_mux_sel,
  output logic                  pc_ld,
  output logic                  ifid_ld,
  output logic                  ifid_clr,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
  output logic [31:0]           freeze_cnt
`endif
);

  stage_shadow_t id_st, ex_st, mem_st, wb_st;
  logic          load_use;

  always_comb begin
    id_st.rd    = ID_rd;
    id_st.rf_en = ID_RF_Enable;
    id_st.load  = ID_Load_Instr;
  end

  always_comb begin
    load_use = ex_st.load &&
               ((ID_uses_rs1 && stage_writes(ex_st, ID_rs1, NUM_REGS)) ||
                (ID_uses_rs2 && stage_writes(ex_st, ID_rs2, NUM_REGS)));
  end

  // Reset forces the free-running defaults even if busy/branch are asserted.
  always_comb begin
    pc_ld      = 1'b1;
    ifid_ld    = 1'b1;
    ifid_clr   = 1'b0;
    cu_mux_sel = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        pc_ld   = 1'b0;
        ifid_ld = 1'b0;
      end else if (branch_taken) begin
        ifid_clr   = 1'b1;
        cu_mux_sel = 1'b1;
      end else if (load_use) begin
        pc_ld      = 1'b0;
        ifid_ld    = 1'b0;
        cu_mux_sel = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_st  <= '0;
      mem_st <= '0;
      wb_st  <= '0;
    end else if (!mem_busy) begin
      wb_st  <= mem_st;
      mem_st <= ex_st;
      ex_st  <= cu_mux_sel ? '0 : id_st;
    end
  end

  fwd_select #(.NUM_REGS(NUM_REGS)) u_fwd_a (
    .rs    (ID_rs1),
    .uses  (ID_uses_rs1),
    .ex_st (ex_st),
    .mem_st(mem_st),
    .wb_st (wb_st),
    .sel   (fwd_a_sel)
  );

  fwd_select #(.NUM_REGS(NUM_REGS)) u_fwd_b (
    .rs    (ID_rs2),
    .uses  (ID_uses_rs2),
    .ex_st (ex_st),
    .mem_st(mem_st),
    .wb_st (wb_st),
    .sel   (fwd_b_sel)
  );

`ifdef HAZARD_PERF_CNT_EN
  // Each counter tracks the condition that actually won output priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else if (mem_busy) begin
      freeze_cnt <= freeze_cnt + 32'd1;
    end else if (branch_taken) begin
      flush_cnt <= flush_cnt + 32'd1;
    end else if (load_use) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
